// File: rtl/shiftreg_ctrl_pkg.sv
// Shared types and constants for the serial shift-register sequencing controller.
package shiftreg_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } sr_state_t;

  // Shift-register direction encodings as seen on the register's dir pin.
  localparam logic SR_LEFT  = 1'b1;  // din enters the LSB, word sent MSB first
  localparam logic SR_RIGHT = 1'b0;  // din enters the MSB, word sent LSB first

endpackage

// File: rtl/shiftreg_ctrl.sv
// Sequencing controller for an N-bit bidirectional serial shift register.
// Accepts a word over a valid/ready command channel, shifts it into the register
// one bit per cycle, captures the register's parallel output and returns it over
// a valid/ready response channel.
module shiftreg_ctrl
  import shiftreg_ctrl_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_data,
  input  logic          cmd_dir,
  input  logic [CW-1:0] cmd_len,
  input  logic          abort,
  output logic          sr_shift_en,
  output logic          sr_dir,
  output logic          sr_din,
  input  logic [N-1:0]  sr_q,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          busy
);

  localparam logic [CW-1:0] N_LEN   = CW'(N);
  localparam logic [CW-1:0] LEN_ONE = {{(CW-1){1'b0}}, 1'b1};

  sr_state_t     state_r;
  sr_state_t     state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] len_r;
  logic [CW-1:0] eff_len_s;
  logic [N-1:0]  hold_r;
  logic [N-1:0]  rsp_data_r;
  logic          shift_en_r;
  logic          dir_r;
  logic          din_r;
  logic          last_s;
  logic          cmd_ready_s;
  logic          rsp_valid_s;
  logic          busy_s;

  // Clamp the requested length to the register width and flag the final shift cycle.
  always_comb begin
    eff_len_s = cmd_len;
    if (cmd_len > N_LEN) begin
      eff_len_s = N_LEN;
    end else begin
      eff_len_s = cmd_len;
    end
    // cnt_r already includes the shift being driven this cycle, so equality means done.
    last_s = (cnt_r == len_r) || abort;
  end

  // State register; reset forces IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          if (eff_len_s != {CW{1'b0}}) begin
            state_next_s = SHIFT;
          end else begin
            state_next_s = CAPTURE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_next_s = CAPTURE;
        end else begin
          state_next_s = SHIFT;
        end
      end
      CAPTURE: state_next_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake and status outputs decoded directly from the state register.
  always_comb begin
    cmd_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    busy_s      = 1'b1;
    case (state_r)
      IDLE: begin
        cmd_ready_s = 1'b1;
        busy_s      = 1'b0;
      end
      SHIFT:   rsp_valid_s = 1'b0;
      CAPTURE: rsp_valid_s = 1'b0;
      RESP:    rsp_valid_s = 1'b1;
      default: busy_s      = 1'b1;
    endcase
  end

  // Datapath: latch the command, feed one bit per SHIFT cycle, capture sr_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CW{1'b0}};
      len_r      <= {CW{1'b0}};
      hold_r     <= {N{1'b0}};
      rsp_data_r <= {N{1'b0}};
      shift_en_r <= 1'b0;
      dir_r      <= 1'b0;
      din_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            len_r <= eff_len_s;
            dir_r <= cmd_dir;
            if (eff_len_s != {CW{1'b0}}) begin
              shift_en_r <= 1'b1;
              cnt_r      <= LEN_ONE;
              // First bit leaves now; the holding register advances toward the sending end.
              if (cmd_dir == SR_LEFT) begin
                din_r  <= cmd_data[N-1];
                hold_r <= {cmd_data[N-2:0], 1'b0};
              end else begin
                din_r  <= cmd_data[0];
                hold_r <= {1'b0, cmd_data[N-1:1]};
              end
            end else begin
              shift_en_r <= 1'b0;
              din_r      <= 1'b0;
              cnt_r      <= {CW{1'b0}};
              hold_r     <= cmd_data;
            end
          end else begin
            shift_en_r <= 1'b0;
            din_r      <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_s) begin
            shift_en_r <= 1'b0;
            din_r      <= 1'b0;
          end else begin
            shift_en_r <= 1'b1;
            cnt_r      <= cnt_r + LEN_ONE;
            if (dir_r == SR_LEFT) begin
              din_r  <= hold_r[N-1];
              hold_r <= {hold_r[N-2:0], 1'b0};
            end else begin
              din_r  <= hold_r[0];
              hold_r <= {1'b0, hold_r[N-1:1]};
            end
          end
        end
        CAPTURE: begin
          shift_en_r <= 1'b0;
          din_r      <= 1'b0;
          rsp_data_r <= sr_q;
        end
        RESP: begin
          shift_en_r <= 1'b0;
          din_r      <= 1'b0;
        end
        default: begin
          shift_en_r <= 1'b0;
          din_r      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_s;
  assign rsp_valid   = rsp_valid_s;
  assign busy        = busy_s;
  assign sr_shift_en = shift_en_r;
  assign sr_dir      = dir_r;
  assign sr_din      = din_r;
  assign rsp_data    = rsp_data_r;

endmodule

// File: doc/shiftreg_ctrl.md
# shiftreg_ctrl

Sequencing controller for the `N`-bit bidirectional serial shift register.
- Accepts a command (parallel word, direction, bit count) over a valid/ready handshake.
- Drives the register's `shift_en`/`dir`/`din` pins so the word is shifted in serially.
- Captures the register's parallel output `q` and returns it over a valid/ready response channel.
- Sits between a host/bus agent and one shift-register instance. It is the register's only driver.

## Interface
Parameters:
- `N`, 8, shift-register width (≥2)
- `CW`, `$clog2(N+1)`, width of the bit-count field

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  controller can accept a command
- `cmd_data`  in  N  word to shift in
- `cmd_dir`  in  1  1 = shift left (`din` enters LSB), 0 = shift right (`din` enters MSB)
- `cmd_len`  in  CW  number of shift cycles
- `abort`  in  1  terminate an in-progress shift sequence early
- `sr_shift_en`  out  1  to register `shift_en`
- `sr_dir`  out  1  to register `dir`
- `sr_din`  out  1  to register `din`
- `sr_q`  in  N  register parallel output
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumer ready
- `rsp_data`  out  N  captured `sr_q`
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states:
  - **IDLE:** `cmd_ready`=1.
    - On `cmd_valid&&cmd_ready`, latch the word, `sr_dir`, and effective length `L = min(cmd_len, N)`.
    - If L>0, go to SHIFT. If L=0, go to CAPTURE.
  - **SHIFT:** `sr_shift_en`=1 for exactly L cycles. Exit to CAPTURE after the L-th cycle or on `abort`.
  - **CAPTURE:** one cycle with `sr_shift_en`=0 so `sr_q` is stable. `rsp_data <= sr_q`. Go to RESP.
  - **RESP:** `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- Bit order:
  - `cmd_dir`=1: send `cmd_data[N-1]` first, then descending. After N shifts, `q == cmd_data`.
  - `cmd_dir`=0: send `cmd_data[0]` first, then ascending. After N shifts, `q == cmd_data`.
- `sr_shift_en`, `sr_dir`, `sr_din`, `rsp_data` are registered outputs. `cmd_ready`, `rsp_valid`, `busy` decode the state register.
- Bit counter: CW bits. It counts shifts issued and never exceeds N.
- `abort`:
  - Sampled only in SHIFT. The shift already asserted in that cycle completes, then the FSM goes to CAPTURE.
  - Ignored in IDLE, CAPTURE and RESP.
- `cmd_len > N` is clamped to N. `cmd_len` = 0 gives no shifts; the response returns the current `q`.
- `cmd_*` are ignored while not in IDLE. No command queuing.
- `sr_dir` holds its last value between commands. `sr_din` drops to 0 outside SHIFT.

## Timing
- Accept at cycle T:
  - `sr_shift_en` is high in cycles T+1 … T+L.
  - CAPTURE at T+L+1.
  - `rsp_valid` first high at T+L+2. Latency is L+2 cycles.
- Response handshake at cycle R: IDLE (`cmd_ready`=1) at R+1, so the next accept is possible at R+1.
- `rsp_valid` and `rsp_data` stay stable until `rsp_ready`, with no upper bound.
- Reset: `rst` high at a posedge forces IDLE from any state, including mid-SHIFT. After that edge:
  - `sr_shift_en`=0, `sr_din`=0, `sr_dir`=0
  - `rsp_valid`=0, `rsp_data`=0, `busy`=0
  - `cmd_ready`=1
  - counter=0
- A command offered in the same cycle as `rst` is dropped.

## Structure
- `shiftreg_ctrl_pkg`:
  - `typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESP} sr_state_t`
  - direction constants `SR_LEFT`=1'b1, `SR_RIGHT`=1'b0
- Single module with no sub-module. The bit source is a local N-bit holding register, shifted toward the sending end each SHIFT cycle.
- The integration top wires `rst_n = ~rst` to the shift-register instance. The bench instantiates the controller plus the register, with the register's interface assertions enabled.

## Test plan
(All cases N=8.)
- **Reset:** `rst` high 2 cycles, from any state → after the edge, `cmd_ready`=1 and every other output 0; `sr_shift_en` never high during reset.
- **Left shift:** `q`=0, cmd `data`=8'hA5, `dir`=1, `len`=8 accepted at T → `sr_din` is 1,0,1,0,0,1,0,1 in T+1..T+8; `rsp_valid` at T+10 with `rsp_data`=8'hA5.
- **Right shift:** cmd `data`=8'h3C, `dir`=0, `len`=8 → `sr_din` is 0,0,1,1,1,1,0,0; `rsp_data`=8'h3C at T+10.
- **Length edge cases:**
  - `len`=0 with `q`=8'h5A → no `sr_shift_en`; `rsp_valid` at T+2 with 8'h5A.
  - `len`=12, `data`=8'hC3 → exactly 8 shifts, `rsp_data`=8'hC3.
- **Abort:** `q`=0, `data`=8'hF0, `dir`=1, `abort` high in cycle T+3 → exactly 3 shifts; `rsp_data`=8'h07 at T+5.
- **Backpressure and mid-shift reset:**
  - `rsp_ready` low for 5 cycles → `rsp_valid` and `rsp_data` held, `cmd_ready`=0, `cmd_valid` ignored; accept again the cycle after the handshake.
  - `rst` in the 4th SHIFT cycle → `sr_shift_en`=0 the next cycle, IDLE.
